// File: rtl/cpu_uart_bridge.sv
// UART 8N1 bridge between the core's CPUOut/CPUIn I/O words and a serial line.
// Toggle handshakes on both directions so software only needs load/store polling.
module cpu_uart_bridge #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] CPUOut,
    output logic [31:0] CPUIn,
    input  logic        RxD,
    output logic        TxD
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] bitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] halfLast = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState;

    uartState      txState;
    logic [CW-1:0] txCnt;
    logic [2:0]    txBit;
    logic [7:0]    txShift;
    logic          txAck;
    logic          txBusy;

    uartState      rxState;
    logic [1:0]    rxSync;
    logic [CW-1:0] rxCnt;
    logic [2:0]    rxBit;
    logic [7:0]    rxShift;
    logic [7:0]    rxByte;
    logic          rxToggle;
    logic          overrun;
    logic          frameErr;

    logic          unusedBits;

    assign unusedBits = ^CPUOut[31:11];
    assign txBusy     = (txState != IDLE);
    assign CPUIn      = {19'b0, frameErr, overrun, txBusy, txAck, rxToggle, rxByte};

    // TxD is registered so the start bit appears on the acceptance edge
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            txState <= IDLE;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
            txAck   <= 1'b0;
            TxD     <= 1'b1;
        end else begin
            unique case (txState)
                IDLE: begin
                    if (CPUOut[8] != txAck) begin
                        txShift <= CPUOut[7:0];
                        txAck   <= CPUOut[8];
                        txCnt   <= '0;
                        TxD     <= 1'b0;
                        txState <= START;
                    end
                end
                START: begin
                    if (txCnt == bitLast) begin
                        txCnt   <= '0;
                        txBit   <= '0;
                        TxD     <= txShift[0];
                        txShift <= {1'b0, txShift[7:1]};
                        txState <= DATA;
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (txCnt == bitLast) begin
                        txCnt <= '0;
                        if (txBit == 3'd7) begin
                            TxD     <= 1'b1;
                            txState <= STOP;
                        end else begin
                            txBit   <= txBit + 1'b1;
                            TxD     <= txShift[0];
                            txShift <= {1'b0, txShift[7:1]};
                        end
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (txCnt == bitLast) begin
                        txCnt   <= '0;
                        txState <= IDLE;
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                default: txState <= IDLE;
            endcase
        end
    end

    // Error clear comes first so a same-cycle error set overrides it
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rxState  <= IDLE;
            rxSync   <= 2'b11;
            rxCnt    <= '0;
            rxBit    <= '0;
            rxShift  <= '0;
            rxByte   <= '0;
            rxToggle <= 1'b0;
            overrun  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxSync <= {rxSync[0], RxD};
            if (CPUOut[10]) begin
                overrun  <= 1'b0;
                frameErr <= 1'b0;
            end
            unique case (rxState)
                IDLE: begin
                    if (!rxSync[1]) begin
                        rxCnt   <= '0;
                        rxState <= START;
                    end
                end
                START: begin
                    if (rxCnt == halfLast) begin
                        rxCnt   <= '0;
                        rxBit   <= '0;
                        rxState <= rxSync[1] ? IDLE : DATA;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rxCnt == bitLast) begin
                        rxCnt   <= '0;
                        rxShift <= {rxSync[1], rxShift[7:1]};
                        if (rxBit == 3'd7) begin
                            rxState <= STOP;
                        end else begin
                            rxBit <= rxBit + 1'b1;
                        end
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rxCnt == bitLast) begin
                        rxCnt   <= '0;
                        rxState <= IDLE;
                        if (!rxSync[1]) begin
                            frameErr <= 1'b1;
                        end else if (rxToggle != CPUOut[9]) begin
                            overrun <= 1'b1;
                        end else begin
                            rxByte   <= rxShift;
                            rxToggle <= ~rxToggle;
                        end
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                default: rxState <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_uart_bridge.sv
// Scoreboard bench for cpu_uart_bridge: line-level TX decoder and RX
// toggle monitor compare against queues filled by a status-word model.
module tb_cpu_uart_bridge;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] CPUOut;
    logic [31:0] CPUIn;
    logic        RxD;
    logic        TxD;

    logic [7:0]  txByte;
    logic        txTog;
    logic        rxAck;
    logic        errClr;

    int          nVec = 0;
    int          nErr = 0;

    logic [7:0]  txQ[$];
    logic [7:0]  rxQ[$];
    logic [7:0]  mHeld;
    logic        mTog;
    logic        mOvr;
    logic        mFe;
    logic        txMonOn;
    logic        rxPrev;
    logic [7:0]  monByte;

    assign CPUOut = {21'b0, errClr, rxAck, txTog, txByte};

    always #5 CLK = ~CLK;

    cpu_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .CPUOut (CPUOut),
        .CPUIn  (CPUIn),
        .RxD    (RxD),
        .TxD    (TxD)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chkRx(input string name);
        chk(name, {CPUIn[31:13], CPUIn[12:11], CPUIn[8:0]},
            {19'b0, mFe, mOvr, mTog, mHeld});
    endtask

    // Drive one frame on RxD and apply the receive rules to the model
    task automatic sendRx(input logic [7:0] b, input logic stopBit,
                          input string name);
        @(negedge CLK);
        RxD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RxD = stopBit;
        repeat (CPB) @(negedge CLK);
        RxD = 1'b1;
        if (!stopBit) begin
            mFe = 1'b1;
        end else if (mTog != rxAck) begin
            mOvr = 1'b1;
        end else begin
            mHeld = b;
            mTog  = ~mTog;
            rxQ.push_back(b);
        end
        repeat (5) @(negedge CLK);
        chkRx(name);
    endtask

    task automatic clearErr();
        @(negedge CLK);
        errClr = 1'b1;
        @(negedge CLK);
        errClr = 1'b0;
        mOvr   = 1'b0;
        mFe    = 1'b0;
        @(negedge CLK);
        chkRx("errClear");
    endtask

    task automatic txIssue(input logic [7:0] b);
        int t;
        t = 0;
        while (!(CPUIn[9] == txTog && !CPUIn[10]) && t < 400) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 400) begin
            nVec++;
            nErr++;
            $display("FAIL txIdleWait: got timeout, want idle within 400");
        end
        txByte = b;
        txTog  = ~txTog;
        txQ.push_back(b);
    endtask

    task automatic waitTxDrain();
        int t;
        t = 0;
        while ((txQ.size() != 0 || CPUIn[10] || CPUIn[9] != txTog) && t < 2000) begin
            @(negedge CLK);
            t++;
        end
        chk("txDrain", txQ.size(), 0);
    endtask

    // Line decoder: samples each bit near its middle
    initial begin
        forever begin
            @(negedge CLK);
            if (txMonOn && !Reset && TxD === 1'b0) begin
                repeat (CPB / 2) @(negedge CLK);
                chk("txStartBit", {31'b0, TxD}, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    monByte[i] = TxD;
                end
                repeat (CPB) @(negedge CLK);
                chk("txStopBit", {31'b0, TxD}, 1);
                if (txQ.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL txUnexpected: got byte %h, want none", monByte);
                end else begin
                    chk("txByte", {24'b0, monByte}, {24'b0, txQ.pop_front()});
                end
            end
        end
    end

    // Each RX toggle flip delivers exactly one expected byte
    initial begin
        rxPrev = 1'b0;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                rxPrev = 1'b0;
            end else if (CPUIn[8] !== rxPrev) begin
                rxPrev = CPUIn[8];
                if (rxQ.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL rxUnexpected: got byte %h, want none", CPUIn[7:0]);
                end else begin
                    chk("rxByte", {24'b0, CPUIn[7:0]}, {24'b0, rxQ.pop_front()});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        logic [7:0] rb;
        logic       sb;

        Reset   = 1'b1;
        RxD     = 1'b1;
        txByte  = 8'h00;
        txTog   = 1'b0;
        rxAck   = 1'b0;
        errClr  = 1'b0;
        mHeld   = 8'h00;
        mTog    = 1'b0;
        mOvr    = 1'b0;
        mFe     = 1'b0;
        txMonOn = 1'b1;

        repeat (3) @(negedge CLK);
        chk("resetCPUIn", CPUIn, 32'h0);
        chk("resetTxD", {31'b0, TxD}, 1);
        Reset = 1'b0;
        repeat (2) @(negedge CLK);

        // Exact TX timing for 0xA5
        txByte = 8'hA5;
        txTog  = 1'b1;
        txQ.push_back(8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        @(posedge CLK);
        #1;
        chk("txAckBusy", {30'b0, CPUIn[10:9]}, 2'b11);
        for (int i = 0; i < 40; i++) begin
            chk("txLine", {31'b0, TxD}, {31'b0, frame[i / CPB]});
            if (i == 39) chk("txBusyLast", {31'b0, CPUIn[10]}, 1);
            @(posedge CLK);
            #1;
        end
        chk("txBusyFall", {31'b0, CPUIn[10]}, 0);
        chk("txIdleHigh", {31'b0, TxD}, 1);

        // Directed receive cases
        sendRx(8'h3C, 1'b1, "rx3C");
        rxAck = mTog;
        sendRx(8'h81, 1'b1, "rx81");
        rxAck = mTog;
        sendRx(8'h11, 1'b1, "rx11");
        sendRx(8'h22, 1'b1, "rxOverrun");
        clearErr();
        sendRx(8'h55, 1'b0, "rxFraming");
        clearErr();
        @(negedge CLK);
        RxD = 1'b0;
        @(negedge CLK);
        RxD = 1'b1;
        repeat (8) @(negedge CLK);
        chkRx("rxGlitch");
        rxAck = mTog;
        sendRx(8'h7E, 1'b1, "rx7E");

        // Random concurrent TX and RX traffic
        fork
            begin
                for (int n = 0; n < 16; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge CLK);
                    txIssue(8'($urandom));
                end
            end
            begin
                for (int n = 0; n < 16; n++) begin
                    rb = 8'($urandom);
                    sb = ($urandom_range(0, 7) != 0);
                    sendRx(rb, sb, "rxRandom");
                    if ($urandom_range(0, 1) == 1) rxAck = mTog;
                    if ((mOvr || mFe) && $urandom_range(0, 1) == 1) clearErr();
                    repeat ($urandom_range(0, 5)) @(negedge CLK);
                end
            end
        join
        waitTxDrain();
        chk("rxQueueEmpty", rxQ.size(), 0);

        // Reset during data bit 3 of 0xFF
        txMonOn = 1'b0;
        @(negedge CLK);
        txByte = 8'hFF;
        txTog  = ~txTog;
        repeat (18) @(negedge CLK);
        chk("preResetBusy", {31'b0, CPUIn[10]}, 1);
        Reset = 1'b1;
        #1;
        chk("midResetTxD", {31'b0, TxD}, 1);
        chk("midResetCPUIn", CPUIn, 32'h0);
        txTog  = 1'b0;
        rxAck  = 1'b0;
        mHeld  = 8'h00;
        mTog   = 1'b0;
        mOvr   = 1'b0;
        mFe    = 1'b0;
        rxQ.delete();
        txQ.delete();
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("postResetCPUIn", CPUIn, 32'h0);
        txMonOn = 1'b1;
        @(negedge CLK);
        txByte = 8'($urandom);
        txTog  = 1'b1;
        txQ.push_back(txByte);
        @(posedge CLK);
        #1;
        chk("freshStartTxD", {31'b0, TxD}, 0);
        chk("freshStartAck", {30'b0, CPUIn[10:9]}, 2'b11);
        waitTxDrain();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
